// File: rtl/notch_biquad_cascade.sv
// rtl/notch_biquad_cascade.sv - cascade of Direct Form I biquads with shadow/active coefficient banks
// One register per section, round-half-up and saturation per stage, atomic commit at a sample gap.
module notch_biquad_cascade #(
  parameter int DATA_WIDTH = 16,
  parameter int COEF_WIDTH = 16,
  parameter int N_SECTIONS = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            valid_i,
  input  logic [DATA_WIDTH-1:0]           data_i,
  output logic                            valid_o,
  output logic [DATA_WIDTH-1:0]           data_o,
  input  logic                            cfg_we,
  input  logic [$clog2(5*N_SECTIONS)-1:0] cfg_addr,
  input  logic [COEF_WIDTH-1:0]           cfg_data,
  input  logic                            cfg_commit,
  output logic                            cfg_busy_o,
  input  logic                            sat_clr,
  output logic                            sat_o
);

  localparam int F      = COEF_WIDTH - 2;
  localparam int N_COEF = 5 * N_SECTIONS;
  localparam int AW     = $clog2(N_COEF);
  localparam int PW     = DATA_WIDTH + COEF_WIDTH;
  localparam int SW     = PW + 3;
  localparam int RW     = SW - F;

  localparam logic [AW:0]                  N_COEF_W = (AW + 1)'(N_COEF);
  localparam logic signed [COEF_WIDTH-1:0] C_ONE    = COEF_WIDTH'(2 ** F);
  localparam logic signed [SW-1:0]         C_RND    = SW'(2 ** (F - 1));
  localparam logic signed [DATA_WIDTH-1:0] D_MAX    = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] D_MIN    = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic signed [COEF_WIDTH-1:0] r_shadow [N_COEF];
  logic signed [COEF_WIDTH-1:0] r_active [N_COEF];
  logic                         r_busy;
  logic                         r_sat;
  logic                         r_valid_o;
  logic [DATA_WIDTH-1:0]        r_data_o;

  logic [N_SECTIONS-1:0]        w_vld;
  logic [N_SECTIONS-1:0]        w_clip;
  logic signed [DATA_WIDTH-1:0] w_y [N_SECTIONS];
  logic                         w_commit;
  logic                         w_addr_ok;

  assign w_addr_ok = ({1'b0, cfg_addr} < N_COEF_W);
  // Swap only when nothing is entering or travelling through the sections.
  assign w_commit  = r_busy & ~valid_i & ~(|w_vld);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_COEF; i++) begin
        r_shadow[i] <= (i % 5 == 0) ? C_ONE : '0;
        r_active[i] <= (i % 5 == 0) ? C_ONE : '0;
      end
    end else begin
      if (cfg_we && !r_busy && w_addr_ok) begin
        r_shadow[cfg_addr] <= $signed(cfg_data);
      end
      if (w_commit) begin
        for (int i = 0; i < N_COEF; i++) begin
          r_active[i] <= r_shadow[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy    <= 1'b0;
      r_sat     <= 1'b0;
      r_valid_o <= 1'b0;
      r_data_o  <= '0;
    end else begin
      if (w_commit) begin
        r_busy <= 1'b0;
      end else if (cfg_commit) begin
        r_busy <= 1'b1;
      end
      if (|w_clip) begin
        r_sat <= 1'b1;
      end else if (sat_clr) begin
        r_sat <= 1'b0;
      end
      r_valid_o <= w_vld[N_SECTIONS-1];
      if (w_vld[N_SECTIONS-1]) begin
        r_data_o <= w_y[N_SECTIONS-1];
      end
    end
  end

  for (genvar s = 0; s < N_SECTIONS; s++) begin : g_sec
    logic signed [DATA_WIDTH-1:0] w_x;
    logic                         w_v;
    logic signed [PW-1:0]         w_p0, w_p1, w_p2, w_p3, w_p4;
    logic signed [SW-1:0]         w_sum;
    logic signed [RW-1:0]         w_shift;
    logic signed [DATA_WIDTH-1:0] w_sat;
    logic                         w_ovf;
    logic                         w_unused_lsb;
    logic signed [DATA_WIDTH-1:0] r_x1, r_x2, r_y1, r_y2, r_y;
    logic                         r_v;

    if (s == 0) begin : g_in_first
      assign w_x = $signed(data_i);
      assign w_v = valid_i;
    end else begin : g_in_chain
      assign w_x = w_y[s-1];
      assign w_v = w_vld[s-1];
    end

    assign w_p0  = PW'(r_active[5*s+0]) * PW'(w_x);
    assign w_p1  = PW'(r_active[5*s+1]) * PW'(r_x1);
    assign w_p2  = PW'(r_active[5*s+2]) * PW'(r_x2);
    assign w_p3  = PW'(r_active[5*s+3]) * PW'(r_y1);
    assign w_p4  = PW'(r_active[5*s+4]) * PW'(r_y2);
    assign w_sum = SW'(w_p0) + SW'(w_p1) + SW'(w_p2) - SW'(w_p3) - SW'(w_p4) + C_RND;

    // Dropping the low F bits of the biased sum is the floor shift, i.e. round half up.
    assign w_shift      = w_sum[SW-1:F];
    assign w_unused_lsb = ^w_sum[F-1:0];
    assign w_ovf        = ~((&w_shift[RW-1:DATA_WIDTH-1]) | ~(|w_shift[RW-1:DATA_WIDTH-1]));
    assign w_sat        = w_ovf ? (w_shift[RW-1] ? D_MIN : D_MAX) : w_shift[DATA_WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_v  <= 1'b0;
        r_y  <= '0;
        r_x1 <= '0;
        r_x2 <= '0;
        r_y1 <= '0;
        r_y2 <= '0;
      end else begin
        r_v <= w_v;
        if (w_commit) begin
          r_x1 <= '0;
          r_x2 <= '0;
          r_y1 <= '0;
          r_y2 <= '0;
        end else if (w_v) begin
          r_y  <= w_sat;
          r_x2 <= r_x1;
          r_x1 <= w_x;
          r_y2 <= r_y1;
          r_y1 <= w_sat;
        end
      end
    end

    assign w_vld[s]  = r_v;
    assign w_y[s]    = r_y;
    assign w_clip[s] = w_v & w_ovf;
  end

  assign valid_o    = r_valid_o;
  assign data_o     = r_data_o;
  assign cfg_busy_o = r_busy;
  assign sat_o      = r_sat;

endmodule
